iccm_loader: RTL and testbench



---
 rtl/iccm_loader_pkg.sv | 24 ++
 rtl/iccm_word_assembler.sv | 94 +++++++++
 rtl/iccm_loader.sv | 158 +++++++++++++++
 tb/tb_iccm_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iccm_loader_pkg.sv
// ---------------------------------------------------------------------------
// iccm_loader_pkg
// Shared definitions for the ICCM boot loader: FSM state encoding, bit
// positions inside the sticky error vector, and the default terminator word.
// Optional feature macro used by the loader: ICCM_LOADER_CSUM_EN.
// ---------------------------------------------------------------------------
package iccm_loader_pkg;

  // Loader FSM states; CHECK is only reachable when the checksum is built in
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FULL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bit positions in err_o
  localparam int ERR_OVF  = 0;
  localparam int ERR_CSUM = 1;

  // Default terminator, truncated or zero-extended to the word width
  localparam logic [63:0] END_WORD_DEFAULT = 64'h0000_0000_0000_0FFF;

endpackage

// File: rtl/iccm_word_assembler.sv
// ---------------------------------------------------------------------------
// iccm_word_assembler
// Packs a UART byte stream little-endian into DATA_W-bit words and drops a
// partial word after TIMEOUT_CYCLES idle cycles (0 disables the timeout).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   enable        bytes are only accepted while high
//   clear         synchronously discards any partial word
//   rx_dv         one-cycle strobe, rx_byte is valid
//   rx_byte       received byte
//   word_valid    one-cycle pulse, word holds a completed word
//   word          last completed word
// ---------------------------------------------------------------------------
module iccm_word_assembler #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int NB = DATA_W / 8;
  localparam logic [3:0] LAST = 4'(NB - 1);

  logic [3:0]        cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] byte_ext;
  logic [DATA_W-1:0] shifted;
  logic              accept;
  logic              expire;

  assign accept   = rx_dv & enable;
  assign byte_ext = DATA_W'(rx_byte);

  // New bytes enter at the top and move down, so after NB bytes the first
  // byte received sits in [7:0]; written with shifts so DATA_W=8 still works
  assign shifted = (acc >> 8) | (byte_ext << (DATA_W - 8));

  // Idle-cycle counter; expiry is an idle cycle, so a byte arriving on the
  // cycle after T-1 idle cycles still joins the partial word
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
      logic [TW-1:0] idle_cnt;

      assign expire = (cnt != 4'd0) && !accept &&
                      (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          idle_cnt <= '0;
        end else if (accept || clear || expire || cnt == 4'd0) begin
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end else begin : g_no_timeout
      assign expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      acc        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt <= 4'd0;
      end else if (accept) begin
        if (cnt == LAST) begin
          cnt        <= 4'd0;
          word       <= shifted;
          word_valid <= 1'b1;
        end else begin
          cnt <= cnt + 4'd1;
          acc <= shifted;
        end
      end else if (expire) begin
        cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/iccm_loader.sv
// ---------------------------------------------------------------------------
// iccm_loader
// Boot loader: turns UART bytes into instruction-memory word writes and holds
// the core in reset until the terminator word (and optionally a checksum)
// has been received.
// Optional feature: define ICCM_LOADER_CSUM_EN to require a trailing checksum
// word (sum of all written words modulo 2^DATA_W) after the terminator.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   rx_dv_i        one-cycle strobe, rx_byte_i valid
//   rx_byte_i      received byte
//   reload_i       in DONE, restarts loading
//   we_o           one-cycle write strobe
//   wmask_o        byte enables, all ones with we_o
//   addr_o         write word address
//   wdata_o        write data
//   core_rst_no    active-low core reset, released in DONE
//   done_o         program loaded
//   err_o          sticky flags: [0] overflow, [1] checksum
//   words_o        number of words written
// ---------------------------------------------------------------------------
module iccm_loader
  import iccm_loader_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 14,
  parameter logic [DATA_W-1:0] END_WORD       = DATA_W'(END_WORD_DEFAULT),
  parameter int                TIMEOUT_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_dv_i,
  input  logic [7:0]          rx_byte_i,
  input  logic                reload_i,
  output logic                we_o,
  output logic [DATA_W/8-1:0] wmask_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic                core_rst_no,
  output logic                done_o,
  output logic [1:0]          err_o,
  output logic [ADDR_W:0]     words_o
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_FULL  = FULL;
  localparam logic [1:0] ST_DONE  = DONE;
`ifdef ICCM_LOADER_CSUM_EN
  localparam logic [1:0] ST_CHECK = CHECK;
`endif

  logic [1:0]        state;
  logic [ADDR_W-1:0] next_addr;
  logic              word_valid;
  logic [DATA_W-1:0] word;
`ifdef ICCM_LOADER_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // Bytes are ignored once loaded; a reload also drops any stray partial word
  iccm_word_assembler #(
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_asm (
    .clk        (clk_i),
    .rst        (rst_i),
    .enable     (state != ST_DONE),
    .clear      (reload_i && state == ST_DONE),
    .rx_dv      (rx_dv_i),
    .rx_byte    (rx_byte_i),
    .word_valid (word_valid),
    .word       (word)
  );

  assign wmask_o     = {NB{we_o}};
  assign done_o      = (state == ST_DONE);
  assign core_rst_no = (state == ST_DONE);

  // Loader FSM plus write port registers. A completed word is handled one
  // cycle after its last byte, so writes and the reset release land two
  // edges after the byte strobe was sampled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_LOAD;
      next_addr <= '0;
      we_o      <= 1'b0;
      addr_o    <= '0;
      wdata_o   <= '0;
      err_o     <= 2'b00;
      words_o   <= '0;
`ifdef ICCM_LOADER_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      we_o <= 1'b0;
      case (state)
        ST_LOAD, ST_FULL: begin
          if (word_valid) begin
            if (word == END_WORD) begin
`ifdef ICCM_LOADER_CSUM_EN
              state <= ST_CHECK;
`else
              state <= ST_DONE;
`endif
            end else if (state == ST_FULL) begin
              err_o[ERR_OVF] <= 1'b1;
            end else begin
              we_o      <= 1'b1;
              addr_o    <= next_addr;
              wdata_o   <= word;
              next_addr <= next_addr + 1'b1;
              words_o   <= words_o + 1'b1;
`ifdef ICCM_LOADER_CSUM_EN
              csum      <= csum + word;
`endif
              if (next_addr == LAST_ADDR) begin
                state <= ST_FULL;
              end
            end
          end
        end
`ifdef ICCM_LOADER_CSUM_EN
        // A bad checksum restarts the image from address 0 so the host can
        // simply retransmit it
        ST_CHECK: begin
          if (word_valid) begin
            if (word == csum) begin
              state <= ST_DONE;
            end else begin
              err_o[ERR_CSUM] <= 1'b1;
              next_addr       <= '0;
              words_o         <= '0;
              csum            <= '0;
              state           <= ST_LOAD;
            end
          end
        end
`endif
        ST_DONE: begin
          if (reload_i) begin
            state     <= ST_LOAD;
            next_addr <= '0;
            words_o   <= '0;
            err_o     <= 2'b00;
`ifdef ICCM_LOADER_CSUM_EN
            csum      <= '0;
`endif
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_iccm_loader.sv
// ---------------------------------------------------------------------------
// tb_iccm_loader
// Self-checking bench for iccm_loader (DATA_W=32, ADDR_W=2, TIMEOUT=10).
// Honours ICCM_LOADER_CSUM_EN when defined for the build.
// ---------------------------------------------------------------------------
module tb_iccm_loader;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 2;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] END_W  = 32'h0000_0FFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        reload;
  logic        we;
  logic [3:0]  wmask;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        core_rst_n;
  logic        done;
  logic [1:0]  err;
  logic [2:0]  words;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_t;

  typedef struct {
    int         n_words;
    int         abort_at;
    int         exp_words;
    logic [1:0] exp_err;
  } vec_t;

  wr_t  obs_q[$];
  vec_t vecs[6];

  iccm_loader #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_dv_i     (rx_dv),
    .rx_byte_i   (rx_byte),
    .reload_i    (reload),
    .we_o        (we),
    .wmask_o     (wmask),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .core_rst_no (core_rst_n),
    .done_o      (done),
    .err_o       (err),
    .words_o     (words)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen between edges
  always @(negedge clk) begin
    if (we) obs_q.push_back('{addr, wdata, wmask});
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; inputs are sampled at the following rising edge
  task automatic apply_stimulus(input logic dv, input logic [7:0] b);
    rx_dv   = dv;
    rx_byte = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, w[8*k +: 8]);
      if (k < 3 && max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    apply_stimulus(1'b0, 8'h00);
    reload = 1'b0;
  endtask

  // Whole-image transaction: expected writes follow from the word list alone
  task automatic run_vector(input string tag, input int n, input int abort_at,
                            input int exp_words, input logic [1:0] exp_err);
    logic [31:0] wl[$];
    wr_t         exp_q[$];
    logic [31:0] sum;
    logic [31:0] w;
    sum = 32'd0;
    pulse_reload();
    check_output({tag, "_reload_core_rst"}, 64'(core_rst_n), 64'd0);
    check_output({tag, "_reload_words"}, 64'(words), 64'd0);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      do w = $urandom; while (w == END_W);
      wl.push_back(w);
      if (i < DEPTH) begin
        exp_q.push_back('{2'(i), w, 4'hF});
        sum += w;
      end
    end
    for (int i = 0; i <= n; i++) begin
      if (i == abort_at) begin
        for (int b = 0; b < int'($urandom_range(1, 3)); b++) apply_stimulus(1'b1, 8'($urandom));
        idle($urandom_range(10, 14));
      end
      if (i < n) begin
        send_word(wl[i], 9);
        idle($urandom_range(0, 3));
      end
    end
    send_word(END_W, 9);
`ifdef ICCM_LOADER_CSUM_EN
    idle($urandom_range(0, 3));
    send_word(sum, 9);
`endif
    idle(3);
    check_output({tag, "_write_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_output({tag, "_addr"}, 64'(obs_q[i].addr), 64'(exp_q[i].addr));
      check_output({tag, "_data"}, 64'(obs_q[i].data), 64'(exp_q[i].data));
      check_output({tag, "_mask"}, 64'(obs_q[i].mask), 64'(exp_q[i].mask));
    end
    check_output({tag, "_words"}, 64'(words), 64'(exp_words));
    check_output({tag, "_err"}, 64'(err), 64'(exp_err));
    check_output({tag, "_done"}, 64'(done), 64'd1);
    check_output({tag, "_core_rst"}, 64'(core_rst_n), 64'd1);
  endtask

  initial begin
    int n;
    int ab;
    vecs[0] = '{1, -1, 1, 2'b00};
    vecs[1] = '{4,  2, 4, 2'b00};
    vecs[2] = '{5, -1, 4, 2'b01};
    vecs[3] = '{0, -1, 0, 2'b00};
    vecs[4] = '{6,  0, 4, 2'b01};
    vecs[5] = '{3,  3, 3, 2'b00};

    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; reload = 1'b0;
    #12;
    check_output("rst_we", 64'(we), 64'd0);
    check_output("rst_wmask", 64'(wmask), 64'd0);
    check_output("rst_addr", 64'(addr), 64'd0);
    check_output("rst_wdata", 64'(wdata), 64'd0);
    check_output("rst_core_rst", 64'(core_rst_n), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_err", 64'(err), 64'd0);
    check_output("rst_words", 64'(words), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic load with exact write and release latency
    apply_stimulus(1'b1, 8'h78);
    apply_stimulus(1'b1, 8'h56);
    apply_stimulus(1'b1, 8'h34);
    apply_stimulus(1'b1, 8'h12);
    check_output("tp1_we_early", 64'(we), 64'd0);
    apply_stimulus(1'b0, 8'h00);
    check_output("tp1_we", 64'(we), 64'd1);
    check_output("tp1_addr", 64'(addr), 64'd0);
    check_output("tp1_wdata", 64'(wdata), 64'h12345678);
    check_output("tp1_wmask", 64'(wmask), 64'hF);
    check_output("tp1_words", 64'(words), 64'd1);
    apply_stimulus(1'b1, 8'hFF);
    check_output("tp1_we_one_cycle", 64'(we), 64'd0);
    apply_stimulus(1'b1, 8'h0F);
    apply_stimulus(1'b1, 8'h00);
    apply_stimulus(1'b1, 8'h00);
`ifdef ICCM_LOADER_CSUM_EN
    send_word(32'h12345678, 0);
`endif
    check_output("tp1_core_rst_early", 64'(core_rst_n), 64'd0);
    apply_stimulus(1'b0, 8'h00);
    check_output("tp1_core_rst", 64'(core_rst_n), 64'd1);
    check_output("tp1_done", 64'(done), 64'd1);
    check_output("tp1_words_final", 64'(words), 64'd1);

    // Reload restarts at address 0
    pulse_reload();
    check_output("reload_core_rst", 64'(core_rst_n), 64'd0);
    check_output("reload_words", 64'(words), 64'd0);
    check_output("reload_done", 64'(done), 64'd0);
    obs_q.delete();
    send_word(32'hCAFE0001, 0);
    idle(2);
    check_output("reload_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) check_output("reload_addr", 64'(obs_q[0].addr), 64'd0);

    // Timeout: a 10-cycle gap drops the partial word, a 9-cycle gap does not
    obs_q.delete();
    apply_stimulus(1'b1, 8'hAA);
    apply_stimulus(1'b1, 8'hBB);
    idle(10);
    send_word(32'h04030201, 0);
    idle(2);
    apply_stimulus(1'b1, 8'hAA);
    apply_stimulus(1'b1, 8'hBB);
    idle(9);
    apply_stimulus(1'b1, 8'hCC);
    apply_stimulus(1'b1, 8'hDD);
    idle(2);
    check_output("tmo_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() > 1) begin
      check_output("tmo_addr0", 64'(obs_q[0].addr), 64'd1);
      check_output("tmo_data0", 64'(obs_q[0].data), 64'h04030201);
      check_output("tmo_addr1", 64'(obs_q[1].addr), 64'd2);
      check_output("tmo_data1", 64'(obs_q[1].data), 64'hDDCCBBAA);
    end
    check_output("tmo_err", 64'(err), 64'd0);

    // Reload outside DONE has no effect
    pulse_reload();
    check_output("reload_ignored_words", 64'(words), 64'd3);

    // Fill the last address, then reset three bytes into the next word
    send_word(32'h11111111, 0);
    idle(2);
    check_output("full_words", 64'(words), 64'd4);
    check_output("full_addr", 64'(addr), 64'd3);
    apply_stimulus(1'b1, 8'hA1);
    apply_stimulus(1'b1, 8'hA2);
    apply_stimulus(1'b1, 8'hA3);
    rx_dv = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_output("midrst_words", 64'(words), 64'd0);
    check_output("midrst_addr", 64'(addr), 64'd0);
    check_output("midrst_wdata", 64'(wdata), 64'd0);
    check_output("midrst_we", 64'(we), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    send_word(32'h44332211, 0);
    idle(2);
    check_output("midrst_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) begin
      check_output("midrst_new_addr", 64'(obs_q[0].addr), 64'd0);
      check_output("midrst_new_data", 64'(obs_q[0].data), 64'h44332211);
    end
    send_word(END_W, 0);
`ifdef ICCM_LOADER_CSUM_EN
    send_word(32'h44332211, 0);
`endif
    idle(2);
    check_output("midrst_done", 64'(done), 64'd1);

`ifdef ICCM_LOADER_CSUM_EN
    // Good checksum
    pulse_reload();
    send_word(32'd1, 0);
    send_word(32'd2, 0);
    send_word(END_W, 0);
    send_word(32'd3, 0);
    idle(2);
    check_output("csum_ok_done", 64'(done), 64'd1);
    check_output("csum_ok_err", 64'(err), 64'd0);
    // Bad checksum restarts the image
    pulse_reload();
    send_word(32'd1, 0);
    send_word(32'd2, 0);
    send_word(END_W, 0);
    send_word(32'd4, 0);
    idle(2);
    check_output("csum_bad_err", 64'(err), 64'b10);
    check_output("csum_bad_core_rst", 64'(core_rst_n), 64'd0);
    check_output("csum_bad_words", 64'(words), 64'd0);
    obs_q.delete();
    send_word(32'd5, 0);
    idle(2);
    check_output("csum_retry_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) check_output("csum_retry_addr", 64'(obs_q[0].addr), 64'd0);
    send_word(END_W, 0);
    send_word(32'd5, 0);
    idle(2);
    check_output("csum_retry_done", 64'(done), 64'd1);
`endif

    // Table of image shapes
    for (int v = 0; v < 6; v++) begin
      run_vector($sformatf("vec%0d", v), vecs[v].n_words, vecs[v].abort_at,
                 vecs[v].exp_words, vecs[v].exp_err);
    end

    // Random image shapes
    for (int r = 0; r < 12; r++) begin
      n  = $urandom_range(0, 6);
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n)) : -1;
      run_vector($sformatf("rnd%0d", r), n, ab, (n < DEPTH) ? n : DEPTH,
                 {1'b0, (n > DEPTH) ? 1'b1 : 1'b0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
